seg_scan_ctrl: RTL

Time-multiplexing controller that shares a single combinational hex-to-7-segment decoder among NUM_DIGITS display digits. Holds a writable digit register file and scans it one digit at a time, with dead time between digits to prevent ghosting. Drives the registered segment bus and active-low digit enables for the game's score and timer display. Optional leading-zero blanking is supported.

---
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with dead time and leading-zero blanking.
// Optional SEG_SCAN_BLINK_EN adds blink_mask and a 16-frame blink phase.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  blank_lz,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [3:0]            dec_nibble,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  scan_wrap
);

    localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DCNT_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned CNT_LAST  = PRESCALE - 1;
    localparam int unsigned DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
    localparam logic [6:0]  SEG_OFF   = 7'h7F;

    typedef enum logic {SHOW, DEAD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wrap_d, wrap_pend_q, advance;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]         seg_d;
    logic [3:0]         digit_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;
    logic               zero_above;
    logic               blank_cur;
    logic               blink_off;

    // Digit register file; out-of-range addresses are dropped
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) digit_reg[i] <= 4'd0;
        end else if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
            digit_reg[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign dec_nibble = digit_reg[idx_q];

    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            zero_above  = zero_above & (digit_reg[i] == 4'd0);
            lz_blank[i] = zero_above;
        end
    end

    assign blank_cur = blank_lz & lz_blank[idx_q];

`ifdef SEG_SCAN_BLINK_EN
    logic [4:0] frame_cnt;

    // Counts frames on the wrap edge so the new phase lines up with digit 0's first SHOW output
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     frame_cnt <= 5'd0;
        else if (wrap_d) frame_cnt <= frame_cnt + 5'd1;
    end

    assign blink_off = frame_cnt[4] & blink_mask[idx_q];
`else
    assign blink_off = 1'b0;
`endif

    // Next-state, scan counters and next output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        advance = 1'b0;
        an_d    = '1;
        seg_d   = SEG_OFF;
        case (state_q)
            SHOW: begin
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
                seg_d = (blank_cur || blink_off) ? SEG_OFF : dec_seg;
                if (cnt_q == CNT_W'(CNT_LAST)) begin
                    cnt_d = '0;
                    if (DEAD_CYCLES == 0) advance = 1'b1;
                    else                  state_d = DEAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEAD: begin
                if (dcnt_q == DCNT_W'(DEAD_LAST)) begin
                    dcnt_d  = '0;
                    advance = 1'b1;
                    state_d = SHOW;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: state_d = SHOW;
        endcase
        if (advance) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State and output registers; scan_wrap is delayed one extra stage to sit on digit 0's first enable
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SHOW;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            idx_q       <= '0;
            wrap_pend_q <= 1'b0;
            an_n        <= '1;
            seg_out     <= SEG_OFF;
            scan_wrap   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            idx_q       <= idx_d;
            wrap_pend_q <= wrap_d;
            an_n        <= an_d;
            seg_out     <= seg_d;
            scan_wrap   <= wrap_pend_q;
        end
    end

endmodule
